skin_thresh_ctrl: RTL and testbench



---
 rtl/skin_pkg.sv | 34 +++
 rtl/skin_thresh_ctrl_if.sv | 10 +
 rtl/frame_edge_det.sv | 27 ++
 rtl/skin_thresh_ctrl.sv | 146 ++++++++++++++
 tb/tb_skin_thresh_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/skin_pkg.sv
// Shared constants and types for the skin-binarization threshold controller.
// Address map, FSM state encoding and reset-default Cb/Cr window.
package skin_pkg;

  localparam logic [2:0] ADDR_CB_MIN = 3'd0;
  localparam logic [2:0] ADDR_CB_MAX = 3'd1;
  localparam logic [2:0] ADDR_CR_MIN = 3'd2;
  localparam logic [2:0] ADDR_CR_MAX = 3'd3;
  localparam logic [2:0] ADDR_COMMIT = 3'd4;

  localparam logic [7:0] CB_MIN_DEF = 8'd77;
  localparam logic [7:0] CB_MAX_DEF = 8'd127;
  localparam logic [7:0] CR_MIN_DEF = 8'd133;
  localparam logic [7:0] CR_MAX_DEF = 8'd173;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    APPLY = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] cb_min;
    logic [7:0] cb_max;
    logic [7:0] cr_min;
    logic [7:0] cr_max;
  } thresh_t;

  // Equal bounds are a legal (single-value) window.
  function automatic logic thresh_ok(input thresh_t t);
    return (t.cb_min <= t.cb_max) && (t.cr_min <= t.cr_max);
  endfunction

endpackage

// File: rtl/skin_thresh_ctrl_if.sv
// Host configuration write channel for skin_thresh_ctrl (req/ack handshake).
interface skin_thresh_ctrl_if;
  logic       cfg_wr_req;
  logic [2:0] cfg_wr_addr;
  logic [7:0] cfg_wr_data;
  logic       cfg_wr_ack;

  modport master (output cfg_wr_req, output cfg_wr_addr, output cfg_wr_data, input cfg_wr_ack);
  modport slave  (input cfg_wr_req, input cfg_wr_addr, input cfg_wr_data, output cfg_wr_ack);
endinterface

// File: rtl/frame_edge_det.sv
// Frame boundary detector: one-cycle fb pulse the cycle after vsync becomes active.
// The history register resets to the inactive level so reset cannot fake a boundary.
module frame_edge_det #(
  parameter bit VS_POL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  output logic fb
);

  logic vs_act;
  logic vs_q;

  assign vs_act = (vsync == VS_POL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q <= 1'b0;
      fb   <= 1'b0;
    end else begin
      vs_q <= vs_act;
      fb   <= vs_act & ~vs_q;
    end
  end

endmodule

// File: rtl/skin_thresh_ctrl.sv
// Cb/Cr skin-window threshold controller: shadow set applied atomically at frame boundary.
// Optional skin-pixel statistics enabled by defining SKIN_STAT_EN.
module skin_thresh_ctrl
  import skin_pkg::*;
#(
  parameter logic [7:0]  CB_MIN_RST = CB_MIN_DEF,
  parameter logic [7:0]  CB_MAX_RST = CB_MAX_DEF,
  parameter logic [7:0]  CR_MIN_RST = CR_MIN_DEF,
  parameter logic [7:0]  CR_MAX_RST = CR_MAX_DEF,
  parameter bit          VS_POL     = 1'b1,
  parameter int unsigned CNT_W      = 22
) (
  input  logic                 clk,
  input  logic                 rst_n,
  skin_thresh_ctrl_if.slave    cfg,
  input  logic                 ycbcr_vsync,
  input  logic                 ycbcr_de,
  input  logic                 monoc,
  output logic [7:0]           cb_min,
  output logic [7:0]           cb_max,
  output logic [7:0]           cr_min,
  output logic [7:0]           cr_max,
  output logic                 cfg_pending,
  output logic                 cfg_err,
  output logic                 commit_done,
  output logic [15:0]          frame_cnt
`ifdef SKIN_STAT_EN
  ,
  output logic [CNT_W-1:0]     skin_cnt,
  output logic                 skin_cnt_valid
`endif
);

  localparam thresh_t RST_SET = '{cb_min: CB_MIN_RST, cb_max: CB_MAX_RST,
                                  cr_min: CR_MIN_RST, cr_max: CR_MAX_RST};

  state_t      state_q, state_d;
  thresh_t     shadow_q, shadow_d, active_q;
  logic        ack_q, ack_d;
  logic        pend_set, apply_ok, apply_bad;
  logic        fb;
  logic [15:0] frame_cnt_q;

  frame_edge_det #(.VS_POL(VS_POL)) u_frame_edge_det (
    .clk   (clk),
    .rst_n (rst_n),
    .vsync (ycbcr_vsync),
    .fb    (fb)
  );

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    ack_d     = 1'b0;
    pend_set  = 1'b0;
    apply_ok  = 1'b0;
    apply_bad = 1'b0;
    case (state_q)
      IDLE: begin
        // Requests are only serviced here, so writes issued while pending stall.
        if (cfg.cfg_wr_req) begin
          ack_d = 1'b1;
          case (cfg.cfg_wr_addr)
            ADDR_CB_MIN: shadow_d.cb_min = cfg.cfg_wr_data;
            ADDR_CB_MAX: shadow_d.cb_max = cfg.cfg_wr_data;
            ADDR_CR_MIN: shadow_d.cr_min = cfg.cfg_wr_data;
            ADDR_CR_MAX: shadow_d.cr_max = cfg.cfg_wr_data;
            ADDR_COMMIT: begin
              state_d  = PEND;
              pend_set = 1'b1;
            end
            default: ;
          endcase
        end
      end
      PEND: begin
        if (fb) state_d = APPLY;
      end
      APPLY: begin
        state_d = IDLE;
        if (thresh_ok(shadow_q)) apply_ok  = 1'b1;
        else                     apply_bad = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shadow_q    <= RST_SET;
      active_q    <= RST_SET;
      ack_q       <= 1'b0;
      cfg_pending <= 1'b0;
      cfg_err     <= 1'b0;
      commit_done <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      ack_q       <= ack_d;
      commit_done <= apply_ok;
      if (apply_ok) active_q <= shadow_q;
      if (apply_ok)       cfg_err <= 1'b0;
      else if (apply_bad) cfg_err <= 1'b1;
      if (pend_set)              cfg_pending <= 1'b1;
      else if (state_q == APPLY) cfg_pending <= 1'b0;
      if (fb) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign cfg.cfg_wr_ack = ack_q;
  assign cb_min         = active_q.cb_min;
  assign cb_max         = active_q.cb_max;
  assign cr_min         = active_q.cr_min;
  assign cr_max         = active_q.cr_max;
  assign frame_cnt      = frame_cnt_q;

`ifdef SKIN_STAT_EN
  logic [CNT_W-1:0] acc_q;
  logic             pix;

  assign pix = ycbcr_de & monoc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q          <= '0;
      skin_cnt       <= '0;
      skin_cnt_valid <= 1'b0;
    end else begin
      skin_cnt_valid <= fb;
      if (fb) begin
        skin_cnt <= acc_q;
        acc_q    <= pix ? CNT_W'(1) : '0;
      end else if (pix && (acc_q != '1)) begin
        acc_q <= acc_q + CNT_W'(1);
      end
    end
  end
`else
  logic                  unused_stat_in;
  localparam int unsigned unused_cnt_w = CNT_W;
  assign unused_stat_in = ycbcr_de ^ monoc;
`endif

endmodule

// File: tb/tb_skin_thresh_ctrl.sv
// Directed self-checking bench for skin_thresh_ctrl; expected active sets are queued
// at commit time and popped when commit_done is observed. Covers SKIN_STAT_EN when defined.
module tb_skin_thresh_ctrl;
  import skin_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync = 1'b0;
  logic        de = 1'b0;
  logic        monoc = 1'b0;
  logic [7:0]  cb_min, cb_max, cr_min, cr_max;
  logic        cfg_pending, cfg_err, commit_done;
  logic [15:0] frame_cnt;
`ifdef SKIN_STAT_EN
  logic [21:0] skin_cnt;
  logic        skin_cnt_valid;
`endif

  skin_thresh_ctrl_if cfg_if ();

  skin_thresh_ctrl #(
    .CB_MIN_RST (8'd77),
    .CB_MAX_RST (8'd127),
    .CR_MIN_RST (8'd133),
    .CR_MAX_RST (8'd173),
    .VS_POL     (1'b1),
    .CNT_W      (22)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg            (cfg_if),
    .ycbcr_vsync    (vsync),
    .ycbcr_de       (de),
    .monoc          (monoc),
    .cb_min         (cb_min),
    .cb_max         (cb_max),
    .cr_min         (cr_min),
    .cr_max         (cr_max),
    .cfg_pending    (cfg_pending),
    .cfg_err        (cfg_err),
    .commit_done    (commit_done),
    .frame_cnt      (frame_cnt)
`ifdef SKIN_STAT_EN
    ,
    .skin_cnt       (skin_cnt),
    .skin_cnt_valid (skin_cnt_valid)
`endif
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          done_cnt = 0;
  logic        prev_done = 1'b0;
  thresh_t     exp_q[$];
  thresh_t     mon_e;
  logic [15:0] exp_frames = '0;

  localparam thresh_t DEF_SET = '{cb_min: 8'd77, cb_max: 8'd127, cr_min: 8'd133, cr_max: 8'd173};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_set(input string tag, input thresh_t e);
    check(tag, {cb_min, cb_max, cr_min, cr_max}, e);
  endtask

  // Scoreboard: every commit_done must match the oldest queued expected set.
  always @(negedge clk) begin
    if (rst_n && commit_done) begin
      done_cnt++;
      check("commit_done_width", {31'd0, prev_done}, 32'd0);
      if (exp_q.size() == 0) begin
        check("spurious_commit_done", {31'd0, commit_done}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("commit_set", {cb_min, cb_max, cr_min, cr_max}, mon_e);
      end
    end
    prev_done = commit_done;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    cfg_if.cfg_wr_req  = 1'b1;
    cfg_if.cfg_wr_addr = a;
    cfg_if.cfg_wr_data = d;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clk);
      if (cfg_if.cfg_wr_ack) got = 1'b1;
    end
    cfg_if.cfg_wr_req = 1'b0;
    check($sformatf("ack_addr%0d", a), {31'd0, got}, 32'd1);
    @(negedge clk);
    check($sformatf("ack_single_addr%0d", a), {31'd0, cfg_if.cfg_wr_ack}, 32'd0);
  endtask

  task automatic vs_pulse();
    @(posedge clk); #1;
    vsync = 1'b1;
    tick(2);
    vsync = 1'b0;
    tick(2);
    exp_frames++;
  endtask

`ifdef SKIN_STAT_EN
  task automatic stat_frame(input int unsigned exp_cnt, input string tag);
    logic got;
    got = 1'b0;
    @(negedge clk);
    vsync = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (i == 2) vsync = 1'b0;
      if (skin_cnt_valid) begin
        got = 1'b1;
        check({tag, "_cnt"}, {10'd0, skin_cnt}, exp_cnt);
      end
    end
    check({tag, "_valid_seen"}, {31'd0, got}, 32'd1);
    @(negedge clk);
    vsync = 1'b0;
    check({tag, "_valid_pulse"}, {31'd0, skin_cnt_valid}, 32'd0);
    tick(2);
    exp_frames++;
  endtask
`endif

  initial begin
    int pre;
    int acks;
    logic got;
    cfg_if.cfg_wr_req  = 1'b0;
    cfg_if.cfg_wr_addr = '0;
    cfg_if.cfg_wr_data = '0;

    // Reset state
    tick(3);
    check_set("reset_set", DEF_SET);
    check("reset_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    check("reset_ack", {31'd0, cfg_if.cfg_wr_ack}, 32'd0);
    check("reset_pending", {31'd0, cfg_pending}, 32'd0);
    check("reset_err", {31'd0, cfg_err}, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Valid commit: cb_min=90, cr_max=160
    cfg_write(ADDR_CB_MIN, 8'd90);
    cfg_write(ADDR_CR_MAX, 8'd160);
    check("shadow_not_active", {cb_min, cr_max}, {8'd77, 8'd173});
    cfg_write(ADDR_COMMIT, 8'd0);
    tick(3);
    check("pending_before_fb", {31'd0, cfg_pending}, 32'd1);
    check_set("active_hold_pend", DEF_SET);
    exp_q.push_back('{cb_min: 8'd90, cb_max: 8'd127, cr_min: 8'd133, cr_max: 8'd160});
    pre = done_cnt;
    vs_pulse();
    tick(2);
    check("commit1_done_cnt", done_cnt, pre + 1);
    check("commit1_pending", {31'd0, cfg_pending}, 32'd0);
    check("commit1_err", {31'd0, cfg_err}, 32'd0);
    check_set("commit1_set", '{cb_min: 8'd90, cb_max: 8'd127, cr_min: 8'd133, cr_max: 8'd160});
    check("frame_cnt_1", {16'd0, frame_cnt}, {16'd0, exp_frames});

    // Inconsistent window rejected, then cleared by a valid commit
    cfg_write(ADDR_CB_MIN, 8'd200);
    cfg_write(ADDR_COMMIT, 8'd0);
    pre = done_cnt;
    vs_pulse();
    tick(2);
    check("reject_no_done", done_cnt, pre);
    check("reject_err", {31'd0, cfg_err}, 32'd1);
    check("reject_pending", {31'd0, cfg_pending}, 32'd0);
    check_set("reject_set", '{cb_min: 8'd90, cb_max: 8'd127, cr_min: 8'd133, cr_max: 8'd160});
    cfg_write(ADDR_CB_MIN, 8'd127);
    cfg_write(ADDR_COMMIT, 8'd0);
    exp_q.push_back('{cb_min: 8'd127, cb_max: 8'd127, cr_min: 8'd133, cr_max: 8'd160});
    vs_pulse();
    tick(2);
    check("recover_done", done_cnt, pre + 1);
    check("recover_err", {31'd0, cfg_err}, 32'd0);

    // Write stalled while a commit is pending
    cfg_write(ADDR_COMMIT, 8'd0);
    exp_q.push_back('{cb_min: 8'd127, cb_max: 8'd127, cr_min: 8'd133, cr_max: 8'd160});
    pre = done_cnt;
    @(posedge clk); #1;
    cfg_if.cfg_wr_req  = 1'b1;
    cfg_if.cfg_wr_addr = ADDR_CR_MIN;
    cfg_if.cfg_wr_data = 8'd140;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (cfg_if.cfg_wr_ack) acks++;
    end
    check("stall_no_ack", acks, 0);
    vsync = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (i == 2) vsync = 1'b0;
      if (cfg_if.cfg_wr_ack) begin
        got = 1'b1;
        check("stall_ack_after_apply", done_cnt, pre + 1);
        cfg_if.cfg_wr_req = 1'b0;
      end
    end
    cfg_if.cfg_wr_req = 1'b0;
    exp_frames++;
    check("stall_ack_seen", {31'd0, got}, 32'd1);
    tick(2);
    check("stall_not_applied", {24'd0, cr_min}, 32'd133);
    cfg_write(ADDR_COMMIT, 8'd0);
    exp_q.push_back('{cb_min: 8'd127, cb_max: 8'd127, cr_min: 8'd140, cr_max: 8'd160});
    vs_pulse();
    tick(2);
    check_set("stall_next_commit", '{cb_min: 8'd127, cb_max: 8'd127, cr_min: 8'd140, cr_max: 8'd160});

    // Reserved address: acknowledged, no effect
    cfg_write(3'd6, 8'd55);
    check("reserved_pending", {31'd0, cfg_pending}, 32'd0);
    check_set("reserved_set", '{cb_min: 8'd127, cb_max: 8'd127, cr_min: 8'd140, cr_max: 8'd160});
    check("frame_cnt_pre_wrap", {16'd0, frame_cnt}, {16'd0, exp_frames});

    // Frame counter wrap, preloaded near the top to keep the run short
    @(negedge clk);
    force dut.frame_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.frame_cnt_q;
    exp_frames = 16'hFFFE;
    vs_pulse();
    vs_pulse();
    check("frame_cnt_wrap0", {16'd0, frame_cnt}, 32'd0);
    vs_pulse();
    check("frame_cnt_wrap1", {16'd0, frame_cnt}, {16'd0, exp_frames});

    // Reset while pending: commit is lost
    cfg_write(ADDR_CB_MAX, 8'd200);
    cfg_write(ADDR_COMMIT, 8'd0);
    check("rst_pend_pending", {31'd0, cfg_pending}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check_set("rst_pend_set", DEF_SET);
    check("rst_pend_pending_clr", {31'd0, cfg_pending}, 32'd0);
    check("rst_pend_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    check("rst_pend_done", {31'd0, commit_done}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    exp_frames = '0;
    pre = done_cnt;
    vs_pulse();
    tick(2);
    check("rst_pend_no_done", done_cnt, pre);
    check("rst_pend_frame_after", {16'd0, frame_cnt}, {16'd0, exp_frames});
    cfg_write(ADDR_COMMIT, 8'd0);
    exp_q.push_back(DEF_SET);
    vs_pulse();
    tick(2);
    check("rst_shadow_default", done_cnt, pre + 1);
    check_set("rst_commit_default", DEF_SET);

`ifdef SKIN_STAT_EN
    // 1000 valid pixels, 300 of them skin
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      de    = 1'b1;
      monoc = (i < 300);
    end
    @(posedge clk); #1;
    de    = 1'b0;
    monoc = 1'b0;
    stat_frame(300, "stat_300");
    stat_frame(0, "stat_empty");
`endif

    check("frame_cnt_final", {16'd0, frame_cnt}, {16'd0, exp_frames});
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
